// File: rtl/vramq_pkg.sv
// Shared types, defaults and the forwarding priority helper for vram_write_queue.
package vramq_pkg;

  localparam int VRAMQ_AW        = 11;
  localparam int VRAMQ_DW        = 8;
  localparam int VRAMQ_DEPTH     = 4;
  // Upper bound on DEPTH that newest_match() can scan.
  localparam int VRAMQ_MAX_DEPTH = 32;
  localparam int VRAMQ_IDX_W     = $clog2(VRAMQ_MAX_DEPTH);

  typedef struct packed {
    logic [VRAMQ_AW-1:0] addr;
    logic [VRAMQ_DW-1:0] data;
  } vramq_entry_t;

  typedef struct packed {
    logic                   hit;
    logic [VRAMQ_IDX_W-1:0] idx;
  } vramq_match_t;

  // Returns the slot of the newest entry flagged in hit_mask. Slots are
  // scanned from oldest (wr_ptr - depth) to newest (wr_ptr - 1) so a later
  // hit overrides an earlier one. depth must be a power of two.
  function automatic vramq_match_t newest_match(
    input logic [VRAMQ_MAX_DEPTH-1:0] hit_mask,
    input int                         wr_ptr,
    input int                         depth
  );
    vramq_match_t           m;
    logic [VRAMQ_IDX_W-1:0] sel;
    m = '0;
    for (int k = VRAMQ_MAX_DEPTH; k >= 1; k--) begin
      if (k <= depth) begin
        sel = VRAMQ_IDX_W'((wr_ptr + depth - k) & (depth - 1));
        if (hit_mask[sel]) begin
          m.hit = 1'b1;
          m.idx = sel;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/vram_write_queue_if.sv
// CPU-side and RAM port-A signal bundle for vram_write_queue.
// slave: the queue itself; master: CPU glue plus RAM port A.
interface vram_write_queue_if
  import vramq_pkg::*;
#(
  parameter int DEPTH = VRAMQ_DEPTH,
  parameter int AW    = VRAMQ_AW,
  parameter int DW    = VRAMQ_DW
);

  localparam int LW = $clog2(DEPTH) + 1;

  // CPU side
  logic          cpu_clken;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;

  // RAM port A
  logic [DW-1:0] ram_q;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;

  modport slave (
    input  cpu_clken, wr_req, wr_addr, wr_data, rd_addr, ram_q,
    output rd_data, full, level, overflow, ram_we, ram_addr, ram_din
  );

  modport master (
    output cpu_clken, wr_req, wr_addr, wr_data, rd_addr, ram_q,
    input  rd_data, full, level, overflow, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/vramq_fifo.sv
// Register-file FIFO of write entries. Exposes every slot plus a valid mask
// so the top level can forward pending data to CPU reads.
// The caller guarantees no push when full without a pop, and no pop when empty.
module vramq_fifo
  import vramq_pkg::*;
#(
  parameter int  DEPTH   = VRAMQ_DEPTH,
  parameter type entry_t = vramq_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int LW      = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output entry_t           entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PW-1:0]    wr_ptr_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] offs;

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    level_d  = level_q + LW'(push_i) - LW'(pop_i);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage.
  // NOTE: the storage array has no reset; slots are only read when valid_o says so.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // A slot is valid when its distance from the read pointer is below the level.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a bit unassigned.
    valid_o = '0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs       = PW'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offs} < level_q);
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign wr_ptr_o  = wr_ptr_q;
  assign level_o   = level_q;
  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);

endmodule

// File: rtl/vram_write_queue.sv
// CPU-side write queue for the dual-port video RAMs.
// Buffers CPU writes, drains one per clk onto RAM port A through registered
// outputs, and forwards pending data to CPU reads of the same address.
// Optional build macro VRAMQ_VBLANK_DRAIN_EN: drain only while vblank=1;
// otherwise the drain is always enabled and vblank is ignored.
// DEPTH must be a power of two, 2..VRAMQ_MAX_DEPTH.
module vram_write_queue
  import vramq_pkg::*;
#(
  parameter int DEPTH = VRAMQ_DEPTH,
  parameter int AW    = VRAMQ_AW,
  parameter int DW    = VRAMQ_DW
) (
  input logic                clk,
  input logic                rst,
  input logic                vblank,
  vram_write_queue_if.slave  q_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic          drain_en;
  logic          cpu_wr;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;
  entry_t        push_entry;
  entry_t        head;
  entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;

  logic          ram_we_q,   ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q,  ram_din_d;
  logic          overflow_q, overflow_d;

  logic [VRAMQ_MAX_DEPTH-1:0] hit_mask;
  vramq_match_t               fwd;
  logic [DW-1:0]              rd_data;

`ifdef VRAMQ_VBLANK_DRAIN_EN
  // Writes pile up during active video and drain only in vertical blank.
  assign drain_en = vblank;
`else
  // Drain continuously; vblank stays on the port but has no effect.
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign drain_en      = 1'b1;
`endif

  // A pop frees a slot in the same cycle, so a push is legal while full if draining.
  assign cpu_wr     = q_if.wr_req & q_if.cpu_clken;
  assign pop        = ~empty & drain_en;
  assign push       = cpu_wr & (~full | pop);
  assign push_entry = {q_if.wr_addr, q_if.wr_data};

  vramq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .entries_o   (entries),
    .valid_o     (valid),
    .wr_ptr_o    (wr_ptr),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Load the head entry into the RAM port on a pop; otherwise hold address/data.
  always_comb begin
    ram_we_d   = pop;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (pop) begin
      ram_addr_d = head.addr;
      ram_din_d  = head.data;
    end
  end

  // Sticky flag for a write dropped because the queue was full and not draining.
  always_comb begin
    overflow_d = overflow_q | (cpu_wr & full & ~pop);
  end

  // RAM port-A output registers and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      overflow_q <= overflow_d;
    end
  end

  // Read forwarding: newest queued match, then the write in flight, then the RAM.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_mask[i] = valid[i] && (entries[i].addr == q_if.rd_addr);
    end
    fwd = newest_match(hit_mask, int'(wr_ptr), DEPTH);
    if (fwd.hit) begin
      rd_data = entries[fwd.idx[PW-1:0]].data;
    end else if (ram_we_q && (ram_addr_q == q_if.rd_addr)) begin
      rd_data = ram_din_q;
    end else begin
      rd_data = q_if.ram_q;
    end
  end

  assign q_if.rd_data  = rd_data;
  assign q_if.ram_we   = ram_we_q;
  assign q_if.ram_addr = ram_addr_q;
  assign q_if.ram_din  = ram_din_q;
  assign q_if.full     = full;
  assign q_if.level    = level;
  assign q_if.overflow = overflow_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed self-checking bench for vram_write_queue (DEPTH=4, AW=11, DW=8).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_vram_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 11;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst;
  logic vblank;
  int   n_vec = 0;
  int   n_err = 0;

  vram_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  vram_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .vblank (vblank),
    .q_if   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_clken = 1'b1;
    bus.wr_req    = 1'b1;
    bus.wr_addr   = a;
    bus.wr_data   = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; vblank = 1'b1;
    bus.cpu_clken = 1'b0; bus.wr_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0; bus.ram_q = 8'hE7;
    tick(); tick();
    n_vec++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_din, bus.level, bus.full, bus.overflow} !== '0) begin
      n_err++;
      $display("FAIL reset: we=%b addr=%h din=%h level=%0d full=%b ovf=%b, want all zero",
               bus.ram_we, bus.ram_addr, bus.ram_din, bus.level, bus.full, bus.overflow);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive_wr(11'h2A5, 8'h3C);
    tick();
    bus.wr_req = 1'b0;
    n_vec++;
    if ({bus.ram_we, bus.level} !== {1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL single_accept: we=%b level=%0d, want we=0 level=1", bus.ram_we, bus.level);
    end
    tick();
    n_vec++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_din, bus.level} !== {1'b1, 11'h2A5, 8'h3C, 3'd0}) begin
      n_err++;
      $display("FAIL single_drain: we=%b addr=%h din=%h level=%0d, want 1 2a5 3c 0",
               bus.ram_we, bus.ram_addr, bus.ram_din, bus.level);
    end
    tick();
    n_vec++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b0, 11'h2A5, 8'h3C}) begin
      n_err++;
      $display("FAIL single_hold: we=%b addr=%h din=%h, want 0 2a5 3c",
               bus.ram_we, bus.ram_addr, bus.ram_din);
    end
  endtask

  task automatic test_clken_gate();
    bus.cpu_clken = 1'b0; bus.wr_req = 1'b1;
    bus.wr_addr = 11'h155; bus.wr_data = 8'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({bus.ram_we, bus.level, bus.overflow} !== '0) begin
        n_err++;
        $display("FAIL clken_gate[%0d]: we=%b level=%0d ovf=%b, want 0 0 0",
                 i, bus.ram_we, bus.level, bus.overflow);
      end
    end
    bus.wr_req = 1'b0; bus.cpu_clken = 1'b1;
  endtask

  task automatic test_forward();
    vblank = 1'b1;
    bus.rd_addr = 11'h010;
    drive_wr(11'h010, 8'h11);
    tick();
    n_vec++;
    if (bus.rd_data !== 8'h11) begin
      n_err++;
      $display("FAIL fwd_queued: rd_data=%h, want 11", bus.rd_data);
    end
    drive_wr(11'h010, 8'h22);
    tick();
    bus.wr_req = 1'b0;
    n_vec++;
    if ({bus.rd_data, bus.ram_we, bus.ram_din} !== {8'h22, 1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL fwd_newest: rd_data=%h we=%b din=%h, want 22 1 11",
               bus.rd_data, bus.ram_we, bus.ram_din);
    end
    tick();
    n_vec++;
    if ({bus.rd_data, bus.level, bus.ram_we, bus.ram_din} !== {8'h22, 3'd0, 1'b1, 8'h22}) begin
      n_err++;
      $display("FAIL fwd_inflight: rd_data=%h level=%0d we=%b din=%h, want 22 0 1 22",
               bus.rd_data, bus.level, bus.ram_we, bus.ram_din);
    end
    bus.rd_addr = 11'h011;
    #1;
    n_vec++;
    if (bus.rd_data !== 8'hE7) begin
      n_err++;
      $display("FAIL fwd_unmatched: rd_data=%h, want e7", bus.rd_data);
    end
    bus.rd_addr = 11'h010;
    tick();
    n_vec++;
    if (bus.rd_data !== 8'hE7) begin
      n_err++;
      $display("FAIL fwd_committed: rd_data=%h, want e7", bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] t_addr [6];
    logic [DW-1:0] t_data [6];
    t_addr = '{11'h100, 11'h101, 11'h100, 11'h3FF, 11'h000, 11'h100};
    t_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    vblank = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive_wr(t_addr[i], t_data[i]);
      else bus.wr_req = 1'b0;
      tick();
      n_vec++;
      if (i >= 1 && i <= 6) begin
        if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, t_addr[i-1], t_data[i-1]}) begin
          n_err++;
          $display("FAIL b2b[%0d]: we=%b addr=%h din=%h, want 1 %h %h",
                   i, bus.ram_we, bus.ram_addr, bus.ram_din, t_addr[i-1], t_data[i-1]);
        end
      end else if (bus.ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL b2b[%0d]: we=%b, want 0", i, bus.ram_we);
      end
    end
    n_vec++;
    if ({bus.level, bus.overflow} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_end: level=%0d ovf=%b, want 0 0", bus.level, bus.overflow);
    end
  endtask

`ifdef VRAMQ_VBLANK_DRAIN_EN
  task automatic test_overflow();
    logic [2:0] e_level [5];
    logic       e_full  [5];
    logic       e_ovf   [5];
    e_level = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    e_full  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    e_ovf   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_wr(11'h200 + AW'(i), 8'h50 + DW'(i));
      tick();
      n_vec++;
      if ({bus.level, bus.full, bus.overflow, bus.ram_we} !== {e_level[i], e_full[i], e_ovf[i], 1'b0}) begin
        n_err++;
        $display("FAIL ovf_fill[%0d]: level=%0d full=%b ovf=%b we=%b, want %0d %b %b 0",
                 i, bus.level, bus.full, bus.overflow, bus.ram_we, e_level[i], e_full[i], e_ovf[i]);
      end
    end
    bus.wr_req = 1'b0;
    vblank = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      n_vec++;
      if (j < 4) begin
        if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 11'h200 + AW'(j), 8'h50 + DW'(j)}) begin
          n_err++;
          $display("FAIL ovf_drain[%0d]: we=%b addr=%h din=%h, want 1 %h %h",
                   j, bus.ram_we, bus.ram_addr, bus.ram_din, 11'h200 + AW'(j), 8'h50 + DW'(j));
        end
      end else if ({bus.ram_we, bus.level, bus.overflow} !== {1'b0, 3'd0, 1'b1}) begin
        n_err++;
        $display("FAIL ovf_end: we=%b level=%0d ovf=%b, want 0 0 1",
                 bus.ram_we, bus.level, bus.overflow);
      end
    end
  endtask

  task automatic test_full_push_pop();
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wr(11'h300 + AW'(i), 8'h60 + DW'(i));
      tick();
    end
    n_vec++;
    if ({bus.level, bus.full} !== {3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL fpp_fill: level=%0d full=%b, want 4 1", bus.level, bus.full);
    end
    drive_wr(11'h304, 8'h64);
    vblank = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    n_vec++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_din, bus.level, bus.full, bus.overflow}
        !== {1'b1, 11'h300, 8'h60, 3'd4, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL fpp_same_cycle: we=%b addr=%h din=%h level=%0d full=%b ovf=%b, want 1 300 60 4 1 0",
               bus.ram_we, bus.ram_addr, bus.ram_din, bus.level, bus.full, bus.overflow);
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_vec++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 11'h300 + AW'(j), 8'h60 + DW'(j)}) begin
        n_err++;
        $display("FAIL fpp_drain[%0d]: we=%b addr=%h din=%h, want 1 %h %h",
                 j, bus.ram_we, bus.ram_addr, bus.ram_din, 11'h300 + AW'(j), 8'h60 + DW'(j));
      end
    end
    tick();
    n_vec++;
    if ({bus.ram_we, bus.level, bus.overflow} !== {1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL fpp_end: we=%b level=%0d ovf=%b, want 0 0 0", bus.ram_we, bus.level, bus.overflow);
    end
  endtask
`endif

  task automatic test_reset_pending();
    logic [2:0] e_pend;
`ifdef VRAMQ_VBLANK_DRAIN_EN
    e_pend = 3'd3;
    vblank = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wr(11'h020 + AW'(i), 8'h70 + DW'(i));
      tick();
    end
    bus.wr_req = 1'b0;
    vblank = 1'b1;
    tick();
`else
    e_pend = 3'd1;
    vblank = 1'b1;
    drive_wr(11'h020, 8'h70);
    tick();
    drive_wr(11'h021, 8'h71);
    tick();
    bus.wr_req = 1'b0;
`endif
    n_vec++;
    if ({bus.ram_we, bus.ram_addr, bus.level} !== {1'b1, 11'h020, e_pend}) begin
      n_err++;
      $display("FAIL rst_setup: we=%b addr=%h level=%0d, want 1 020 %0d",
               bus.ram_we, bus.ram_addr, bus.level, e_pend);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({bus.ram_we, bus.level, bus.full, bus.overflow} !== '0) begin
      n_err++;
      $display("FAIL rst_pending: we=%b level=%0d full=%b ovf=%b, want all zero",
               bus.ram_we, bus.level, bus.full, bus.overflow);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (bus.ram_we !== 1'b0) begin
        n_err++;
        $display("FAIL rst_quiet[%0d]: we=%b addr=%h, want we=0", i, bus.ram_we, bus.ram_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clken_gate();
    test_forward();
    test_back_to_back();
`ifdef VRAMQ_VBLANK_DRAIN_EN
    test_overflow();
`endif
    test_reset_pending();
`ifdef VRAMQ_VBLANK_DRAIN_EN
    test_full_push_pop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
